frac_baud_gen: RTL



---
 rtl/frac_baud_gen_pkg.sv | 12 +
 rtl/frac_baud_gen_if.sv | 31 +++
 rtl/frac_baud_gen_frac_div_core.sv | 93 +++++++++
 rtl/frac_baud_gen.sv | 75 +++++++
 4 files changed

// File: rtl/frac_baud_gen_pkg.sv
// Shared UART SoC clocking defaults and the helper that derives the oversample index width.
package frac_baud_gen_pkg;

  localparam int unsigned DivWDefault   = 16;
  localparam int unsigned FracWDefault  = 4;
  localparam int unsigned OsRateDefault = 16;

  function automatic int unsigned os_width(input int unsigned os_rate);
    return (os_rate > 1) ? $clog2(os_rate) : 1;
  endfunction

endpackage

// File: rtl/frac_baud_gen_if.sv
// Control/status bundle between the UART TX/RX (master) and the baud generator (slave).
interface frac_baud_gen_if
  import frac_baud_gen_pkg::*;
#(
  parameter int unsigned DIV_W  = DivWDefault,
  parameter int unsigned FRAC_W = FracWDefault,
  parameter int unsigned OS_W   = os_width(OsRateDefault)
);

  logic              enable;
  logic              restart;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              tick_os;
  logic              tick_bit;
  logic [OS_W-1:0]   os_phase;
  logic              clk_out;
  logic              cfg_err;

  modport master (
    output enable, restart, div_int, div_frac, div_load,
    input  tick_os, tick_bit, os_phase, clk_out, cfg_err
  );

  modport slave (
    input  enable, restart, div_int, div_frac, div_load,
    output tick_os, tick_bit, os_phase, clk_out, cfg_err
  );

endinterface

// File: rtl/frac_baud_gen_frac_div_core.sv
// Fractional divider: shadow/active divisor, period counter and fractional accumulator.
// Produces a registered oversample tick plus the combinational boundary it is derived from.
module frac_baud_gen_frac_div_core #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              restart_i,
  input  logic [DIV_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  input  logic              div_load_i,
  output logic              boundary_o,
  output logic              tick_os_o,
  output logic              cfg_err_o
);

  logic [DIV_W-1:0]  shd_int_q, shd_int_d, act_int_q, act_int_d, cnt_q, cnt_d;
  logic [FRAC_W-1:0] shd_frac_q, shd_frac_d, act_frac_q, act_frac_d, acc_q, acc_d;
  logic              carry_q, carry_d, pend_q, pend_d, tick_q, tick_d, cfg_err_q, cfg_err_d;
  logic [DIV_W:0]    period;
  logic [FRAC_W:0]   acc_sum;
  logic              bad, boundary, apply;

  always_comb begin
    period   = {1'b0, act_int_q} + {{DIV_W{1'b0}}, carry_q};
    acc_sum  = {1'b0, acc_q} + {1'b0, act_frac_q};
    bad      = act_int_q < DIV_W'(2);
    // >= rather than == so a divisor shrunk mid-period cannot strand cnt above P-1
    boundary = enable_i & ~restart_i & ~bad & ({1'b0, cnt_q} >= period - (DIV_W + 1)'(1));
    apply    = boundary | ~enable_i | restart_i | bad;

    shd_int_d  = div_load_i ? div_int_i : shd_int_q;
    shd_frac_d = div_load_i ? div_frac_i : shd_frac_q;
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    if (apply && (pend_q || div_load_i)) begin
      act_int_d  = shd_int_d;
      act_frac_d = shd_frac_d;
    end
    pend_d = (pend_q | div_load_i) & ~apply;

    cnt_d   = cnt_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    tick_d  = 1'b0;
    if (restart_i) begin
      cnt_d   = '0;
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (boundary) begin
      cnt_d            = '0;
      {carry_d, acc_d} = acc_sum;
      tick_d           = 1'b1;
    end else if (enable_i && !bad) begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    cfg_err_d = enable_i & (act_int_d < DIV_W'(2));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shd_int_q  <= '0;
      shd_frac_q <= '0;
      act_int_q  <= '0;
      act_frac_q <= '0;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      tick_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      shd_int_q  <= shd_int_d;
      shd_frac_q <= shd_frac_d;
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      tick_q     <= tick_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign boundary_o = boundary;
  assign tick_os_o  = tick_q;
  assign cfg_err_o  = cfg_err_q;

endmodule

// File: rtl/frac_baud_gen.sv
// Fractional baud generator: oversample tick, bit tick, oversample phase and 50% bit clock.
module frac_baud_gen
  import frac_baud_gen_pkg::*;
#(
  parameter int unsigned DIV_W   = DivWDefault,
  parameter int unsigned FRAC_W  = FracWDefault,
  parameter int unsigned OS_RATE = OsRateDefault
) (
  input  logic            clk_in,
  input  logic            reset_n,
  frac_baud_gen_if.slave  bus
);

  localparam int unsigned OS_W = os_width(OS_RATE);
  localparam int unsigned Half = OS_RATE / 2;

  logic            boundary;
  logic [OS_W-1:0] os_phase_q, os_phase_d;
  logic            tick_bit_q, tick_bit_d, clk_out_q, clk_out_d;

  frac_baud_gen_frac_div_core #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_core (
    .clk_i      (clk_in),
    .rst_ni     (reset_n),
    .enable_i   (bus.enable),
    .restart_i  (bus.restart),
    .div_int_i  (bus.div_int),
    .div_frac_i (bus.div_frac),
    .div_load_i (bus.div_load),
    .boundary_o (boundary),
    .tick_os_o  (bus.tick_os),
    .cfg_err_o  (bus.cfg_err)
  );

  // Phase/clock updates use the boundary so they land on the same edge as tick_os.
  always_comb begin
    os_phase_d = os_phase_q;
    clk_out_d  = clk_out_q;
    tick_bit_d = 1'b0;
    if (bus.restart) begin
      os_phase_d = '0;
      clk_out_d  = 1'b0;
    end else if (boundary) begin
      if (os_phase_q == OS_W'(OS_RATE - 1)) begin
        os_phase_d = '0;
        tick_bit_d = 1'b1;
        clk_out_d  = 1'b1;
      end else begin
        os_phase_d = os_phase_q + OS_W'(1);
        if (os_phase_q == OS_W'(Half - 1)) begin
          clk_out_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      os_phase_q <= '0;
      tick_bit_q <= 1'b0;
      clk_out_q  <= 1'b0;
    end else begin
      os_phase_q <= os_phase_d;
      tick_bit_q <= tick_bit_d;
      clk_out_q  <= clk_out_d;
    end
  end

  assign bus.os_phase = os_phase_q;
  assign bus.tick_bit = tick_bit_q;
  assign bus.clk_out  = clk_out_q;

endmodule
